// File: rtl/sr_lru_arb_if.sv
// sr_lru_arb_if
//   Requester-side bundle for the sr_lru_arb two-port LRU arbiter.
//   It carries both requesters' req/ack handshakes, command fields and
//   returned pop data.
//
//   Parameters: ADDR_W (LRU entry address width), DATA_W (LRU data width)
//   Signals per requester N (0/1):
//     reqN    request, held by the requester until ackN
//     weN     1 = push (write), 0 = pop (read)
//     addrN   entry address
//     wdataN  push data
//     ackN    one-cycle completion pulse from the arbiter
//     rdataN  pop result, valid while ackN is high
//   Modports: master (requester side), slave (arbiter side).
interface sr_lru_arb_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      input  ack0, rdata0,
      input  ack1, rdata1
   );

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      output ack0, rdata0,
      output ack1, rdata1
   );
endinterface

// File: rtl/sr_lru_arb.sv
// sr_lru_arb
//   Two-port arbiter and sequencer for the single LRU tracker on the
//   sr_cpu push/pop interface. One requester is picked per transaction,
//   its command is latched, exactly one lruWrite or lruRead strobe is
//   issued to the tracker, and the transaction is completed with a
//   one-cycle ack (carrying pop data on rdataN).
//   Sequence: IDLE (arbitrate + latch) -> ISSUE (strobe) -> RESP (ack).
//
//   Ports:
//     clk       clock, all state on the rising edge
//     rst_n     asynchronous active-low reset
//     req_if    requester bundle (sr_lru_arb_if.slave): req/we/addr/wdata
//               in, ack/rdata out, for requesters 0 and 1
//     busy      high in ISSUE and RESP
//     lruWrite  push strobe to the tracker (ISSUE cycle only)
//     lruRead   pop strobe to the tracker (ISSUE cycle only)
//     lruAddr   tracker address (latched command address)
//     lruIn     tracker write data (latched command data)
//     lruOut    tracker read data, valid in the lruRead cycle
//
//   Configuration macro: SR_LRU_ARB_FIXED_PRIO_EN
//     defined   -> requester 0 always wins simultaneous requests
//     undefined -> round-robin using the last_gnt register (default)
module sr_lru_arb #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   sr_lru_arb_if.slave       req_if,
   output logic              busy,
   output logic              lruWrite,
   output logic              lruRead,
   output logic [ADDR_W-1:0] lruAddr,
   output logic [DATA_W-1:0] lruIn,
   input  logic [DATA_W-1:0] lruOut
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              id_q, id_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              gnt;

   // Winner selection. A lone requester always wins; contention is
   // resolved either by fixed priority or by favouring the requester
   // that was not granted last.
`ifdef SR_LRU_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt = 1'b0;
      if (req_if.req1 && !req_if.req0) begin
         gnt = 1'b1;
      end
   end
`else
   logic last_gnt_q, last_gnt_d;

   always_comb begin
      gnt = 1'b0;
      if (req_if.req0 && req_if.req1) begin
         gnt = ~last_gnt_q;
      end else if (req_if.req1) begin
         gnt = 1'b1;
      end
   end

   // last_gnt resets to 1 so requester 0 wins the first contention.
   always_comb begin
      last_gnt_d = last_gnt_q;
      if (state_q == IDLE && (req_if.req0 || req_if.req1)) begin
         last_gnt_d = gnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= 1'b1;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end
`endif

   // Next-state and command-register update.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (req_if.req0 || req_if.req1) begin
               id_d    = gnt;
               we_d    = gnt ? req_if.we1    : req_if.we0;
               addr_d  = gnt ? req_if.addr1  : req_if.addr0;
               wdata_d = gnt ? req_if.wdata1 : req_if.wdata0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // Pop data is only valid during the strobe cycle, so capture it here.
            if (!we_q) begin
               rdata_d = lruOut;
            end
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         id_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs are decoded straight from registered state so that an
   // asynchronous reset drops strobes and acks in the same instant.
   always_comb begin
      busy          = (state_q != IDLE);
      lruWrite      = (state_q == ISSUE) &&  we_q;
      lruRead       = (state_q == ISSUE) && !we_q;
      lruAddr       = addr_q;
      lruIn         = wdata_q;
      req_if.ack0   = (state_q == RESP) && !id_q;
      req_if.ack1   = (state_q == RESP) &&  id_q;
      req_if.rdata0 = rdata_q;
      req_if.rdata1 = rdata_q;
   end

endmodule

// File: tb/tb_sr_lru_arb.sv
// tb_sr_lru_arb
//   Directed self-checking bench for sr_lru_arb. Inputs change and outputs
//   are sampled on the falling clock edge; the design acts on the rising
//   edge. Expected values are hand-derived constants.
module tb_sr_lru_arb;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;

   logic              clk;
   logic              rst_n;
   logic              busy;
   logic              lruWrite;
   logic              lruRead;
   logic [ADDR_W-1:0] lruAddr;
   logic [DATA_W-1:0] lruIn;
   logic [DATA_W-1:0] lruOut;

   int errors = 0;
   int checks = 0;

   sr_lru_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sr_lru_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_if   (bus),
      .busy     (busy),
      .lruWrite (lruWrite),
      .lruRead  (lruRead),
      .lruAddr  (lruAddr),
      .lruIn    (lruIn),
      .lruOut   (lruOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the directed sequence somehow stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic r0, input logic w0,
                                input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                input logic r1, input logic w1,
                                input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
      bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
      bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
   endtask

   initial begin
      logic exp_id;
      rst_n  = 1'b0;
      lruOut = '0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      nextCycle();

      // Reset state
      checkOutput("rst_ack0",     bus.ack0,   0);
      checkOutput("rst_ack1",     bus.ack1,   0);
      checkOutput("rst_rdata0",   bus.rdata0, 0);
      checkOutput("rst_rdata1",   bus.rdata1, 0);
      checkOutput("rst_busy",     busy,       0);
      checkOutput("rst_lruWrite", lruWrite,   0);
      checkOutput("rst_lruRead",  lruRead,    0);
      checkOutput("rst_lruAddr",  lruAddr,    0);
      checkOutput("rst_lruIn",    lruIn,      0);
      rst_n = 1'b1;
      nextCycle();
      checkOutput("idle_busy", busy, 0);

      // Single pop from requester 0
      applyStimulus(1, 0, 3'd5, 8'h00, 0, 0, 0, 0);
      lruOut = 8'hA7;
      nextCycle();
      checkOutput("pop_lruRead",  lruRead,  1);
      checkOutput("pop_lruWrite", lruWrite, 0);
      checkOutput("pop_lruAddr",  lruAddr,  5);
      checkOutput("pop_busy",     busy,     1);
      checkOutput("pop_ack0_early", bus.ack0, 0);
      nextCycle();
      checkOutput("pop_ack0",    bus.ack0,   1);
      checkOutput("pop_ack1",    bus.ack1,   0);
      checkOutput("pop_rdata0",  bus.rdata0, 8'hA7);
      checkOutput("pop_strobe",  lruRead,    0);
      checkOutput("pop_busy_r",  busy,       1);
      bus.req0 = 1'b0;
      nextCycle();
      checkOutput("pop_ack0_drop", bus.ack0, 0);
      checkOutput("pop_busy_end",  busy,     0);

      // Single push from requester 1
      lruOut = 8'hFF;
      applyStimulus(0, 0, 0, 0, 1, 1, 3'd2, 8'h3C);
      nextCycle();
      checkOutput("push_lruWrite", lruWrite, 1);
      checkOutput("push_lruRead",  lruRead,  0);
      checkOutput("push_lruAddr",  lruAddr,  2);
      checkOutput("push_lruIn",    lruIn,    8'h3C);
      nextCycle();
      checkOutput("push_ack1",      bus.ack1,   1);
      checkOutput("push_ack0",      bus.ack0,   0);
      checkOutput("push_wr_off",    lruWrite,   0);
      checkOutput("push_rd_off",    lruRead,    0);
      checkOutput("push_rdata_kept", bus.rdata1, 8'hA7);
      bus.req1 = 1'b0;
      nextCycle();
      checkOutput("push_busy_end", busy, 0);

      // Contention: both held for four transactions
      lruOut = 8'h55;
      applyStimulus(1, 0, 3'd1, 8'h00, 1, 0, 3'd6, 8'h00);
      for (int k = 0; k < 4; k++) begin
`ifdef SR_LRU_ARB_FIXED_PRIO_EN
         exp_id = 1'b0;
`else
         exp_id = k[0];
`endif
         nextCycle();
         checkOutput($sformatf("cont%0d_lruRead", k), lruRead, 1);
         checkOutput($sformatf("cont%0d_lruAddr", k), lruAddr, exp_id ? 6 : 1);
         nextCycle();
         checkOutput($sformatf("cont%0d_ack0", k), bus.ack0, {31'd0, ~exp_id});
         checkOutput($sformatf("cont%0d_ack1", k), bus.ack1, {31'd0, exp_id});
         nextCycle();
         checkOutput($sformatf("cont%0d_busy", k), busy, 0);
         if (k == 3) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
         end
      end
      nextCycle();
      checkOutput("cont_quiet", busy, 0);

      // Early drop: req0 held for one cycle only
      lruOut = 8'h9E;
      applyStimulus(1, 0, 3'd3, 8'h00, 0, 0, 0, 0);
      nextCycle();
      bus.req0 = 1'b0;
      checkOutput("drop_lruRead", lruRead, 1);
      checkOutput("drop_lruAddr", lruAddr, 3);
      nextCycle();
      checkOutput("drop_ack0",   bus.ack0,   1);
      checkOutput("drop_rdata0", bus.rdata0, 8'h9E);
      nextCycle();
      checkOutput("drop_busy_end", busy, 0);

      // Late request: req1 rises during ISSUE of a requester 0 push
      applyStimulus(1, 1, 3'd4, 8'h11, 0, 0, 0, 0);
      nextCycle();
      checkOutput("late_lruWrite", lruWrite, 1);
      checkOutput("late_lruIn",    lruIn,    8'h11);
      bus.req1  = 1'b1;
      bus.we1   = 1'b0;
      bus.addr1 = 3'd7;
      lruOut    = 8'hC3;
      nextCycle();
      checkOutput("late_ack0", bus.ack0, 1);
      checkOutput("late_ack1", bus.ack1, 0);
      bus.req0 = 1'b0;
      nextCycle();
      checkOutput("late_idle_busy", busy,     0);
      checkOutput("late_idle_ack1", bus.ack1, 0);
      nextCycle();
      checkOutput("late_lruRead", lruRead, 1);
      checkOutput("late_lruAddr", lruAddr, 7);
      nextCycle();
      checkOutput("late_ack1_r",  bus.ack1,   1);
      checkOutput("late_rdata1",  bus.rdata1, 8'hC3);
      bus.req1 = 1'b0;
      nextCycle();
      checkOutput("late_busy_end", busy, 0);

      // Reset mid-ISSUE of a push from requester 0 (last grant now 0)
      applyStimulus(1, 1, 3'd5, 8'h77, 0, 0, 0, 0);
      nextCycle();
      checkOutput("rmid_lruWrite_pre", lruWrite, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rmid_lruWrite", lruWrite,   0);
      checkOutput("rmid_busy",     busy,       0);
      checkOutput("rmid_ack0",     bus.ack0,   0);
      checkOutput("rmid_lruAddr",  lruAddr,    0);
      checkOutput("rmid_lruIn",    lruIn,      0);
      checkOutput("rmid_rdata0",   bus.rdata0, 0);
      bus.req0 = 1'b0;
      nextCycle();
      checkOutput("rmid_ack0_hold", bus.ack0, 0);
      rst_n = 1'b1;
      nextCycle();
      checkOutput("rmid_ack0_after", bus.ack0, 0);

      // First contention after reset must go to requester 0
      lruOut = 8'h21;
      applyStimulus(1, 0, 3'd1, 8'h00, 1, 0, 3'd6, 8'h00);
      nextCycle();
      checkOutput("post_rst_lruAddr", lruAddr, 1);
      nextCycle();
      checkOutput("post_rst_ack0", bus.ack0, 1);
      checkOutput("post_rst_ack1", bus.ack1, 0);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      nextCycle();
      nextCycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
